// File: rtl/key_evt_pkg.sv
// -----------------------------------------------------------------------------
// key_evt_pkg
// Shared definitions for the key event classifier and its consumers.
//   - state_t       : classifier gesture states
//   - EVT_*         : event codes, also usable by the PWM duty/mode control
//   - ms_to_ticks() : converts a millisecond interval to clock ticks
// -----------------------------------------------------------------------------
package key_evt_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESSED = 3'd1,
        WAIT2   = 3'd2,
        PRESS2  = 3'd3,
        LHELD   = 3'd4
    } state_t;

    localparam int EVT_W = 3;

    localparam logic [EVT_W-1:0] EVT_NONE   = 3'd0;
    localparam logic [EVT_W-1:0] EVT_SHORT  = 3'd1;
    localparam logic [EVT_W-1:0] EVT_LONG   = 3'd2;
    localparam logic [EVT_W-1:0] EVT_DOUBLE = 3'd3;
    localparam logic [EVT_W-1:0] EVT_REPEAT = 3'd4;

    // Result is 64 bits wide; callers truncate to their own timer width.
    function automatic longint unsigned ms_to_ticks(input int unsigned ms,
                                                    input int unsigned freq_mhz);
        return longint'(ms) * 64'd1000 * longint'(freq_mhz);
    endfunction

endpackage

// File: rtl/key_hold_timer.sv
// -----------------------------------------------------------------------------
// key_hold_timer
// Clearable, saturating up-counter with a terminal-value compare.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : forces the count to 0 on the next edge
//   term        : terminal value X; expired is high while count == X-1
//   expired     : terminal compare result (combinational from the count)
// -----------------------------------------------------------------------------
module key_hold_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] term,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + CNT_W'(1);
        end
    end

    // Expiry is reported one count early so the registered event lands
    // exactly X+1 clocks after the triggering pulse.
    assign expired = (count == (term - CNT_W'(1)));

endmodule

// File: rtl/key_event_classifier.sv
// -----------------------------------------------------------------------------
// key_event_classifier
// Classifies debounced key gestures (active-low key) into single-cycle
// short_press / long_press / double_click pulses, plus an optional
// auto-repeat pulse while long-held.
//
// Build option: define KEY_REPEAT_EN to enable key_repeat generation.
// Without it key_repeat is tied to 0.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   key_level     : debounced level (0 = pressed), guards press in IDLE
//   key_press     : one-cycle pulse on debounced falling edge
//   key_release   : one-cycle pulse on debounced rising edge
//   short_press   : single press released before LONG, no second press
//   long_press    : key held for LONG_MS
//   double_click  : second press of a double click released
//   key_repeat    : every REPEAT_MS while long-held (KEY_REPEAT_EN only)
//   busy          : state is not IDLE
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no gesture in progress
// PRESSED | first press down, timing towards LONG
// WAIT2   | first press released, waiting for a second press
// PRESS2  | second press down, double click decided on its release
// LHELD   | long press reported, waiting for release (repeat if enabled)
// -----------------------------------------------------------------------------
module key_event_classifier
    import key_evt_pkg::*;
#(
    parameter int unsigned FREQ      = 50,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned DCLICK_MS = 300,
`ifdef KEY_REPEAT_EN
    parameter int unsigned REPEAT_MS = 200,
`endif
    parameter int          CNT_W     = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_level,
    input  logic key_press,
    input  logic key_release,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic key_repeat,
    output logic busy
);

    localparam logic [CNT_W-1:0] LONG_T = CNT_W'(ms_to_ticks(LONG_MS, FREQ));
    localparam logic [CNT_W-1:0] DCLK_T = CNT_W'(ms_to_ticks(DCLICK_MS, FREQ));
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_T  = CNT_W'(ms_to_ticks(REPEAT_MS, FREQ));
`endif

    state_t           state;
    state_t           state_next;
    logic [EVT_W-1:0] evt_next;
    logic             rpt_clear;
    logic             timer_clear;
    logic [CNT_W-1:0] term;
    logic             expired;
    logic             press_v;
    logic             release_v;

    // A press and release in the same cycle is a glitch: drop both.
    assign press_v   = key_press & ~key_release;
    assign release_v = key_release & ~key_press;

    always_comb begin
        term = '1;
        case (state)
            PRESSED: term = LONG_T;
            WAIT2:   term = DCLK_T;
`ifdef KEY_REPEAT_EN
            LHELD:   term = RPT_T;
`endif
            default: term = '1;
        endcase
    end

    assign timer_clear = (state_next != state) | rpt_clear;

    key_hold_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .term    (term),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Key edges are checked before expiry so a release/press landing on the
    // expiry cycle wins over the timeout event.
    always_comb begin
        state_next = state;
        evt_next   = EVT_NONE;
        rpt_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (press_v && !key_level) begin
                    state_next = PRESSED;
                end
            end
            PRESSED: begin
                if (release_v) begin
                    state_next = WAIT2;
                end else if (expired) begin
                    state_next = LHELD;
                    evt_next   = EVT_LONG;
                end
            end
            WAIT2: begin
                if (press_v) begin
                    state_next = PRESS2;
                end else if (expired) begin
                    state_next = IDLE;
                    evt_next   = EVT_SHORT;
                end
            end
            PRESS2: begin
                if (release_v) begin
                    state_next = IDLE;
                    evt_next   = EVT_DOUBLE;
                end
            end
            LHELD: begin
                if (release_v) begin
                    state_next = IDLE;
`ifdef KEY_REPEAT_EN
                end else if (expired) begin
                    evt_next  = EVT_REPEAT;
                    rpt_clear = 1'b1;
`endif
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
        end else begin
            short_press  <= (evt_next == EVT_SHORT);
            long_press   <= (evt_next == EVT_LONG);
            double_click <= (evt_next == EVT_DOUBLE);
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_repeat <= 1'b0;
        end else begin
            key_repeat <= (evt_next == EVT_REPEAT);
        end
    end
`else
    assign key_repeat = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: doc/key_event_classifier.md
# key_event_classifier

Consumes the debounced key level and edge pulses produced by the key debouncer and classifies each key gesture into one of three single-cycle event pulses: short press, long press, or double click. An optional hold auto-repeat pulse can be compiled in. It sits between the debouncer and the PWM duty/mode control logic, which acts on these event pulses instead of raw edges. The key is active-low: a press is the level going 0, and a release is the level going 1.

## Interface
- FREQ, 50: clock frequency in MHz.
- LONG_MS, 1000: hold time in ms that qualifies a long press.
- DCLICK_MS, 300: maximum gap in ms from the first release to the second press.
- REPEAT_MS, 200: auto-repeat period in ms (used only with KEY_REPEAT_EN).
- CNT_W, 32: timer width; must hold LONG_MS*1000*FREQ.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- key_level  in  1  debounced key level (0 = pressed).
- key_press  in  1  one-cycle pulse on a debounced falling edge.
- key_release  in  1  one-cycle pulse on a debounced rising edge.
- short_press  out  1  one-cycle pulse: a single press was released before LONG, and no second press followed.
- long_press  out  1  one-cycle pulse: the key has been held for LONG_MS.
- double_click  out  1  one-cycle pulse: the second press of a double click was released.
- key_repeat  out  1  one-cycle pulse every REPEAT_MS while the key is long-held.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Tick constants: LONG_T = LONG_MS*1000*FREQ, DCLK_T = DCLICK_MS*1000*FREQ, RPT_T = REPEAT_MS*1000*FREQ. All are computed at CNT_W width.
- Timer behaviour:
  - The timer clears on every state transition.
  - Otherwise it increments by 1 per clock and saturates at its all-ones value.
  - "Expiry" of X means timer == X-1.
- States and transitions:
  - IDLE: key_press moves to PRESSED.
  - PRESSED:
    - key_release moves to WAIT2.
    - LONG_T expiry moves to LHELD and fires long_press.
  - WAIT2:
    - key_press moves to PRESS2.
    - DCLK_T expiry moves to IDLE and fires short_press.
  - PRESS2:
    - key_release moves to IDLE and fires double_click.
    - The hold length during the second press is ignored.
  - LHELD:
    - key_release moves to IDLE with no event.
    - With KEY_REPEAT_EN, RPT_T expiry fires key_repeat and clears the timer; the state stays LHELD.
- Simultaneous key_press and key_release in one cycle are treated as a glitch: both are ignored, and the state and timer continue as if neither was asserted.
- key_press while in PRESSED, PRESS2 or LHELD is ignored.
- key_release while in IDLE or WAIT2 is ignored.
- A release arriving in the same cycle as LONG_T expiry in PRESSED goes to WAIT2, and no long_press fires (release wins).
- A press arriving in the same cycle as DCLK_T expiry in WAIT2 goes to PRESS2, and no short_press fires.
- key_level is used only as a guard: in IDLE, key_press is accepted only if key_level == 0. This rejects a stale pulse.
- At most one event output is high in any cycle.

## Timing
- Reset values: short_press, long_press, double_click, key_repeat and busy are all 0. The state is IDLE and the timer is 0.
- Reset mid-gesture aborts the gesture with no event.
- After reset, a key that is already held is not seen as a press until a fresh key_press pulse arrives.
- Event outputs are registered and assert exactly one clock after the decisive cycle (the key_release cycle or the expiry cycle).
- busy rises one clock after the accepted key_press. It falls in the same clock that the terminal event pulse asserts, or one clock after the release from LHELD.
- Latency to short_press: DCLK_T+1 clocks after key_release.
- Latency to long_press: LONG_T+1 clocks after key_press.

## Configuration
- KEY_REPEAT_EN defined: LHELD emits key_repeat every RPT_T clocks. The first repeat pulse comes RPT_T clocks after long_press.
- KEY_REPEAT_EN undefined: the key_repeat port remains but is tied to 0. The repeat compare logic and the REPEAT_MS usage are absent.

## Structure
- Shared package key_evt_pkg contains:
  - the state encoding: IDLE, PRESSED, WAIT2, PRESS2, LHELD;
  - a ms-to-ticks constant function;
  - the event code constants, for reuse by the PWM control logic.
- Sub-module key_hold_timer holds the clearable, saturating CNT_W counter. It has a clear input and an expiry-compare output for a given terminal value. It is instantiated once, with the compare value muxed by state.

## Test plan
All scenarios use FREQ=1, LONG_MS=1, DCLICK_MS=1 and REPEAT_MS=1, which gives 1000 ticks each.
- Short press: press, release 200 clocks later, then no press. short_press fires 1001 clocks after the release; no other event fires.
- Long press: press held for 2500 clocks. long_press fires 1001 clocks after the press. The release produces no event, and busy is 0 afterwards.
- Double click: press, release at +100, press at +400, release at +500. double_click fires one clock after the second release; short_press never fires.
- Boundary cases, each run separately:
  - Release exactly on the LONG expiry cycle: the block enters WAIT2, long_press does not fire, and short_press fires later.
  - Second press exactly on the DCLK expiry cycle: double_click fires on its release.
- Repeat (KEY_REPEAT_EN defined), hold for 3500 clocks: long_press, then key_repeat pulses at 1000 and 2000 clocks after long_press. Rebuilt without the macro: key_repeat stays 0.
- Reset and glitch handling:
  - rst_n pulsed low while in PRESS2: no events fire and busy goes to 0 immediately.
  - After reset with key_level 0 and no key_press pulse: the block stays IDLE.
  - key_press and key_release asserted together in IDLE: the block stays IDLE.
